// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: widths, FSM states,
// per-port request bundle and port indices.
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lock_wdog.sv
// Lock watchdog: counts cycles spent in an owned state and fires once the owner
// has held the bus for LOCK_MAX consecutive locked cycles, counting the acquiring grant.
module dmem_lock_wdog #(
    parameter int LOCK_MAX = 16
) (
    input  logic CLK,
    input  logic clear,
    input  logic owned,
    output logic fire
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    logic [CNT_W-1:0] cnt;

    // The acquiring grant happens in IDLE, so the owned-cycle count lags by one.
    assign fire = owned && (cnt == CNT_W'(LOCK_MAX - 2));

    always_ff @(posedge CLK) begin
        if (clear) begin
            cnt <= '0;
        end else if (owned && !fire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with per-port bus lock sharing the single-port data memory
// between core (port 0) and host (port 1). Build macro DMEM_ARB_STATS_EN adds stats counters.
//
// state | meaning
// IDLE  | no owner; single request granted, tie goes to port != last_gnt
// OWN0  | core holds the lock; host stalls
// OWN1  | host holds the lock; core stalls
module dmem_arbiter #(
    parameter int ADDR_W   = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W   = dmem_arb_pkg::DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              CLK,
    input  logic              start,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_to,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
    output logic [15:0]       stall_cnt
`endif
);

    import dmem_arb_pkg::*;

    arb_state_t state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic       wd_fire;
    dmem_req_t  rq0, rq1, sel;

    assign rq0 = '{we: we[0], lock: lock[0], addr: addr0, wdata: wdata0};
    assign rq1 = '{we: we[1], lock: lock[1], addr: addr1, wdata: wdata1};
    assign sel = gnt[PORT_HOST] ? rq1 : rq0;

    always_comb begin
        gnt          = 2'b00;
        state_nxt    = state;
        last_gnt_nxt = last_gnt;

        case (state)
            IDLE:    gnt = (req == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : req;
            OWN0:    gnt = {1'b0, req[0]};
            OWN1:    gnt = {req[1], 1'b0};
            default: gnt = 2'b00;
        endcase
        if (start) begin
            gnt = 2'b00;
        end

        case (state)
            IDLE: begin
                if (|gnt && sel.lock) begin
                    state_nxt = gnt[PORT_HOST] ? OWN1 : OWN0;
                end
            end
            OWN0:    if (wd_fire || !lock[0]) state_nxt = IDLE;
            OWN1:    if (wd_fire || !lock[1]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (gnt[PORT_CORE]) begin
            last_gnt_nxt = PORT_CORE;
        end else if (gnt[PORT_HOST]) begin
            last_gnt_nxt = PORT_HOST;
        end
        // A forced release hands the next tie to the non-owner even if the owner was idle.
        if (wd_fire) begin
            last_gnt_nxt = (state == OWN1) ? PORT_HOST : PORT_CORE;
        end
    end

    assign mem_en    = |gnt;
    assign mem_we    = mem_en & sel.we;
    assign mem_addr  = mem_en ? sel.addr  : '0;
    assign mem_wdata = mem_en ? sel.wdata : '0;

    always_ff @(posedge CLK) begin
        if (start) begin
            state    <= IDLE;
            last_gnt <= PORT_HOST;
            lock_to  <= 1'b0;
            rvalid   <= 2'b00;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
            rvalid   <= gnt & ~we;
            if (wd_fire) begin
                lock_to <= 1'b1;
            end
            if (|(gnt & ~we)) begin
                rdata <= mem_rdata;
            end
        end
    end

    dmem_lock_wdog #(
        .LOCK_MAX (LOCK_MAX)
    ) u_wdog (
        .CLK   (CLK),
        .clear (start || (state == IDLE)),
        .owned (state != IDLE),
        .fire  (wd_fire)
    );

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (start) begin
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt[0] && (gnt_cnt0 != 16'hFFFF)) begin
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            end
            if (gnt[1] && (gnt_cnt1 != 16'hFFFF)) begin
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            end
            if (|(req & ~gnt) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, round-robin, streaming reads, host lock,
// watchdog release and reset during an in-flight read, against a bench-owned memory.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       start;
    logic [1:0] req, we, lock;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       lock_to, mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [256];
    logic       preload = 1'b0;
    logic [7:0] wtbl [4] = '{8'h12, 8'h34, 8'h56, 8'h78};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .LOCK_MAX (16)
    ) dut (
        .CLK       (CLK),
        .start     (start),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .lock_to   (lock_to),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Asynchronous-read memory model; contents seeded with addr ^ 8'hA5.
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b1; preload = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b expected 00", i, gnt); end
            n_chk++;
            if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en[%0d]: got %b expected 0", i, mem_en); end
            tick();
            n_chk++;
            if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid[%0d]: got %b expected 00", i, rvalid); end
            n_chk++;
            if (lock_to !== 1'b0) begin n_fail++; $display("FAIL reset_lock_to[%0d]: got %b expected 0", i, lock_to); end
            n_chk++;
            if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rdata); end
        end
        start = 1'b0; preload = 1'b0; req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        logic [7:0] exp_d;
        req = 2'b11; we = 2'b00; lock = 2'b00; addr0 = 8'h10; addr1 = 8'h20;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (i % 2 == 1) ? 8'h85 : 8'hB5;
            #1;
            n_chk++;
            if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, exp_g); end
            tick();
            n_chk++;
            if (rvalid !== exp_g) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, exp_g); end
            n_chk++;
            if (rdata !== exp_d) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, rdata, exp_d); end
        end
        req = 2'b00;
    endtask

    task automatic test_back_to_back();
        req = 2'b01; we = 2'b00; lock = 2'b00; addr0 = 8'hFF;
        #1;
        n_chk++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt0: got %b expected 01", gnt); end
        n_chk++;
        if (mem_addr !== 8'hFF) begin n_fail++; $display("FAIL b2b_mem_addr: got %h expected ff", mem_addr); end
        tick();
        addr0 = 8'h00;
        n_chk++;
        if (rvalid !== 2'b01) begin n_fail++; $display("FAIL b2b_rvalid0: got %b expected 01", rvalid); end
        n_chk++;
        if (rdata !== 8'h5A) begin n_fail++; $display("FAIL b2b_rdata0: got %h expected 5a", rdata); end
        #1;
        n_chk++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt1: got %b expected 01", gnt); end
        tick();
        req = 2'b00;
        n_chk++;
        if (rvalid !== 2'b01) begin n_fail++; $display("FAIL b2b_rvalid1: got %b expected 01", rvalid); end
        n_chk++;
        if (rdata !== 8'hA5) begin n_fail++; $display("FAIL b2b_rdata1: got %h expected a5", rdata); end
        tick();
        n_chk++;
        if (rvalid !== 2'b00) begin n_fail++; $display("FAIL b2b_rvalid_idle: got %b expected 00", rvalid); end
        n_chk++;
        if (rdata !== 8'hA5) begin n_fail++; $display("FAIL b2b_rdata_hold: got %h expected a5", rdata); end
    endtask

    task automatic test_host_lock();
        req = 2'b11; we = 2'b10; addr0 = 8'h05;
        for (int c = 0; c < 4; c++) begin
            addr1 = 8'(c + 1); wdata1 = wtbl[c];
            lock = (c < 3) ? 2'b10 : 2'b00;
            #1;
            n_chk++;
            if (gnt !== 2'b10) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected 10", c, gnt); end
            n_chk++;
            if (mem_we !== 1'b1 || mem_addr !== 8'(c + 1) || mem_wdata !== wtbl[c]) begin
                n_fail++;
                $display("FAIL lock_mem[%0d]: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         c, mem_we, mem_addr, mem_wdata, 8'(c + 1), wtbl[c]);
            end
            tick();
            n_chk++;
            if (rvalid !== 2'b00) begin n_fail++; $display("FAIL lock_wr_rvalid[%0d]: got %b expected 00", c, rvalid); end
        end
        req = 2'b01; we = 2'b00; lock = 2'b00;
        #1;
        n_chk++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL lock_core_gnt: got %b expected 01", gnt); end
        tick();
        n_chk++;
        if (rvalid !== 2'b01 || rdata !== 8'hA0) begin
            n_fail++; $display("FAIL lock_core_read: got rvalid=%b rdata=%h expected 01/a0", rvalid, rdata);
        end
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            addr1 = 8'(i + 1);
            #1;
            n_chk++;
            if (gnt !== 2'b10) begin n_fail++; $display("FAIL readback_gnt[%0d]: got %b expected 10", i, gnt); end
            tick();
            n_chk++;
            if (rvalid !== 2'b10 || rdata !== wtbl[i]) begin
                n_fail++;
                $display("FAIL readback[%0d]: got rvalid=%b rdata=%h expected 10/%h", i, rvalid, rdata, wtbl[i]);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_watchdog();
        logic [1:0] exp_g;
        logic       exp_lt;
        we = 2'b00; lock = 2'b10; addr0 = 8'h40; addr1 = 8'h30;
        for (int cy = 1; cy <= 20; cy++) begin
            req    = (cy == 1) ? 2'b10 : 2'b11;
            exp_g  = (cy == 17) ? 2'b01 : 2'b10;
            exp_lt = (cy >= 17);
            #1;
            n_chk++;
            if (gnt !== exp_g) begin n_fail++; $display("FAIL wdog_gnt[%0d]: got %b expected %b", cy, gnt, exp_g); end
            n_chk++;
            if (lock_to !== exp_lt) begin n_fail++; $display("FAIL wdog_lock_to[%0d]: got %b expected %b", cy, lock_to, exp_lt); end
            tick();
        end
        req = 2'b00; lock = 2'b00;
        tick();
    endtask

    task automatic test_restart();
        req = 2'b01; we = 2'b00; lock = 2'b00; addr0 = 8'h07;
        #1;
        n_chk++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL restart_read_gnt: got %b expected 01", gnt); end
        tick();
        start = 1'b1;
        #1;
        n_chk++;
        if (gnt !== 2'b00 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL restart_start_outputs: got gnt=%b mem_en=%b expected 00/0", gnt, mem_en);
        end
        tick();
        start = 1'b0; req = 2'b11;
        #1;
        n_chk++;
        if (rvalid !== 2'b00) begin n_fail++; $display("FAIL restart_rvalid: got %b expected 00", rvalid); end
        n_chk++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL restart_rdata: got %h expected 00", rdata); end
        n_chk++;
        if (lock_to !== 1'b0) begin n_fail++; $display("FAIL restart_lock_to: got %b expected 0", lock_to); end
        n_chk++;
        if (gnt !== 2'b01) begin n_fail++; $display("FAIL restart_tie_gnt: got %b expected 01", gnt); end
        tick();
        req = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_host_lock();
        test_watchdog();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
